wb_initiator: RTL
=================

WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 Parameter ADDR_W, 3, Wishbone byte-address width; wb_adr_o carries bits [ADDR_W-1:2].
REQ-002 Parameter TIMEOUT, 255, max cycles from stb assertion to ack/err/rty before abort; range 1..65535.
REQ-003 Parameter MAX_RETRY, 3, number of re-issues after rty before reporting error; range 0..15.
REQ-004 clk_i  in  1  single clock; all logic on the rising edge.
REQ-005 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid_i / req_ready_o  in/out  1/1  command handshake; a command transfers when both are high on a clock edge.
REQ-007 req_we_i  in  1  1 = write, 0 = read.
REQ-008 req_adr_i  in  ADDR_W  byte address; bits [1:0] are ignored.
REQ-009 req_dat_i / req_sel_i  in  32/4  write data and byte select.
REQ-010 rsp_valid_o  out  1  one-cycle response pulse.
REQ-011 rsp_dat_o  out  32  read data, valid with rsp_valid_o; 0 for writes.
REQ-012 rsp_err_o / rsp_tmo_o  out  1/1  status flags, valid with rsp_valid_o.
REQ-013 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  pipelined Wishbone master controls.
REQ-014 wb_adr_o, wb_sel_o, wb_dat_o  out  ADDR_W-2/4/32  master address, select and data.
REQ-015 wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i  in  1/1/1/1/32  slave response inputs.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-017 req_ready_o SHALL be high only in IDLE; an accepted command SHALL be registered and the FSM SHALL enter ISSUE on the next edge.
REQ-018 In ISSUE: cyc=1, stb=1, with adr/sel/we/dat taken from the registered command; the FSM moves to WAIT on the first edge where wb_stall_i=0.
REQ-019 In WAIT: cyc=1, stb=0; the acknowledge inputs (ack/err/rty) SHALL be sampled only in WAIT and ignored in every other state.
REQ-020 Simultaneous acknowledge inputs SHALL resolve with priority err > rty > ack.
REQ-021 On ack: rsp_dat_o captures wb_dat_i (reads only), err=0, tmo=0; the FSM enters RESP and cyc drops on the same edge.
REQ-022 On err: the FSM enters RESP with rsp_err_o=1.
REQ-023 On rty: if retry count < MAX_RETRY, the count increments and the FSM returns to ISSUE with cyc held high; otherwise the FSM enters RESP with rsp_err_o=1.
REQ-024 A 16-bit timeout counter SHALL clear on entry to ISSUE and increment every cycle in ISSUE or WAIT.
REQ-025 When the counter reaches TIMEOUT, the FSM enters RESP with rsp_tmo_o=1 and rsp_err_o=1; an ack arriving in that same cycle wins and the transaction completes normally.
REQ-026 RESP SHALL last exactly one cycle with rsp_valid_o=1, then go to IDLE; the retry count clears on entry to IDLE.
REQ-027 Minimum latency: command accepted at edge N, stb high N to N+1, ack sampled at N+2, rsp_valid_o high N+2 to N+3, req_ready_o high again from N+3.
REQ-028 Only one transaction SHALL be outstanding at a time; req_valid_i SHALL be ignored outside IDLE.
REQ-029 All Wishbone and response outputs SHALL be registered; wb_stb_o SHALL never be high while wb_cyc_o is low.

Reset
REQ-030 Asserting rst_n_i SHALL immediately force IDLE and zero all outputs except req_ready_o, which SHALL be 1.
REQ-031 Reset during ISSUE or WAIT SHALL drop cyc/stb without producing a response; the aborted command is lost.
REQ-032 Counters and command registers SHALL reset to 0.

Structure
REQ-033 Package wb_initiator_pkg SHALL hold the state enum, the default TIMEOUT and MAX_RETRY constants, and the 32-bit data width constant.
REQ-034 The block SHALL be a single module with no sub-modules; it SHALL be verifiable against the generated WB register banks used as slaves.

Verification
REQ-035 Read adr 0x4 against a slave acking 2 cycles after stb with data 0xCAFE0001 -> one rsp_valid_o pulse, rsp_dat_o=0xCAFE0001, err=0, tmo=0.
REQ-036 Write 0xDEADBEEF, sel=0xF, adr 0x0 with stall held high for 3 cycles -> stb held high 4 cycles with adr/dat stable, then a single response with err=0.
REQ-037 Slave asserts rty on every attempt with MAX_RETRY=3 -> exactly 4 stb pulses, cyc continuous throughout, final response err=1, tmo=0.
REQ-038 Slave never acks with TIMEOUT=10 -> response exactly 10 cycles after stb first rises, tmo=1, err=1, cyc low afterwards.
REQ-039 Slave asserts err and ack together -> response with err=1; a second case asserts ack exactly at the timeout cycle -> err=0, tmo=0.
REQ-040 Reset asserted in WAIT -> cyc/stb low asynchronously, no rsp_valid_o pulse, req_ready_o=1 after reset release, and the next command completes normally.

Source files
------------

// File: rtl/wb_initiator_pkg.sv
// ----------------------------------------------------------------------------
// wb_initiator_pkg
// Shared types and constants for the Wishbone initiator:
//   - state_e        : transaction FSM states
//   - DATA_W / SEL_W : Wishbone data and byte-select widths
//   - TIMEOUT_DEF    : default abort limit, in cycles from stb assertion
//   - MAX_RETRY_DEF  : default number of re-issues after a retry response
// ----------------------------------------------------------------------------
package wb_initiator_pkg;

    localparam int DATA_W        = 32;
    localparam int SEL_W         = DATA_W / 8;
    localparam int TIMEOUT_DEF   = 255;
    localparam int MAX_RETRY_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage : wb_initiator_pkg

// File: rtl/wb_initiator.sv
// ----------------------------------------------------------------------------
// wb_initiator
// Single-outstanding pipelined Wishbone master. A command taken on the
// req_* handshake is registered, issued on the bus (stb held through stall),
// and completed by ack, err, retry exhaustion or timeout. Each command yields
// exactly one rsp_valid_o pulse.
//
// Ports
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o : command handshake (ready only while idle)
//   req_we_i, req_adr_i,
//   req_dat_i, req_sel_i    : command write-enable, byte address, data, select
//   rsp_valid_o             : one-cycle response pulse
//   rsp_dat_o               : read data (0 for writes), valid with rsp_valid_o
//   rsp_err_o, rsp_tmo_o    : error / timeout flags, valid with rsp_valid_o
//   wb_cyc_o, wb_stb_o,
//   wb_we_o, wb_adr_o,
//   wb_sel_o, wb_dat_o      : Wishbone master outputs (all registered)
//   wb_ack_i, wb_err_i,
//   wb_rty_i, wb_stall_i,
//   wb_dat_i                : Wishbone slave responses
// ----------------------------------------------------------------------------
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int ADDR_W    = 3,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,

    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_adr_i,
    input  logic [DATA_W-1:0] req_dat_i,
    input  logic [SEL_W-1:0]  req_sel_i,

    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_dat_o,
    output logic              rsp_err_o,
    output logic              rsp_tmo_o,

    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-3:0] wb_adr_o,
    output logic [SEL_W-1:0]  wb_sel_o,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_rty_i,
    input  logic              wb_stall_i,
    input  logic [DATA_W-1:0] wb_dat_i
);

    // Timeout fires on the edge where the counter would reach TIMEOUT.
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRY);

    state_e              state_q,     state_d;
    logic                req_ready_q, req_ready_d;
    logic                cyc_q,       cyc_d;
    logic                stb_q,       stb_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_dat_q,   rsp_dat_d;
    logic                rsp_err_q,   rsp_err_d;
    logic                rsp_tmo_q,   rsp_tmo_d;
    logic                cmd_we_q,    cmd_we_d;
    logic [ADDR_W-3:0]   cmd_adr_q,   cmd_adr_d;
    logic [SEL_W-1:0]    cmd_sel_q,   cmd_sel_d;
    logic [DATA_W-1:0]   cmd_dat_q,   cmd_dat_d;
    logic [15:0]         tmo_cnt_q,   tmo_cnt_d;
    logic [3:0]          retry_cnt_q, retry_cnt_d;
    logic                tmo_hit;

    // Byte-lane bits of the address are not carried on the word-addressed bus.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^req_adr_i[1:0];

    always_comb begin
        // NOTE: every _d signal gets a default before the case so that no
        // path through the FSM holds a value combinationally (no latches).
        state_d     = state_q;
        cmd_we_d    = cmd_we_q;
        cmd_adr_d   = cmd_adr_q;
        cmd_sel_d   = cmd_sel_q;
        cmd_dat_d   = cmd_dat_q;
        tmo_cnt_d   = tmo_cnt_q;
        retry_cnt_d = retry_cnt_q;
        rsp_dat_d   = '0;
        rsp_err_d   = 1'b0;
        rsp_tmo_d   = 1'b0;
        tmo_hit     = (tmo_cnt_q == TMO_LAST);

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    cmd_we_d  = req_we_i;
                    cmd_adr_d = req_adr_i[ADDR_W-1:2];
                    cmd_sel_d = req_sel_i;
                    cmd_dat_d = req_dat_i;
                    tmo_cnt_d = '0;
                    state_d   = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                if (tmo_hit) begin
                    state_d   = ST_RESP;
                    rsp_err_d = 1'b1;
                    rsp_tmo_d = 1'b1;
                end else if (!wb_stall_i) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                // Any slave response outranks a timeout landing on the same edge.
                if (wb_err_i) begin
                    state_d   = ST_RESP;
                    rsp_err_d = 1'b1;
                end else if (wb_rty_i) begin
                    if (retry_cnt_q < RETRY_LIM) begin
                        retry_cnt_d = retry_cnt_q + 4'd1;
                        tmo_cnt_d   = '0;
                        state_d     = ST_ISSUE;
                    end else begin
                        state_d   = ST_RESP;
                        rsp_err_d = 1'b1;
                    end
                end else if (wb_ack_i) begin
                    state_d   = ST_RESP;
                    rsp_dat_d = cmd_we_q ? '0 : wb_dat_i;
                end else if (tmo_hit) begin
                    state_d   = ST_RESP;
                    rsp_err_d = 1'b1;
                    rsp_tmo_d = 1'b1;
                end
            end

            ST_RESP: begin
                retry_cnt_d = '0;
                state_d     = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        // Bus and handshake outputs are decoded from the next state so they
        // leave a flop aligned with the state they belong to.
        cyc_d       = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
        stb_d       = (state_d == ST_ISSUE);
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of the others. The command registers
    // are reset along with the control flops so outputs are defined to 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_adr_q   <= '0;
            cmd_sel_q   <= '0;
            cmd_dat_q   <= '0;
            tmo_cnt_q   <= '0;
            retry_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
            cmd_we_q    <= cmd_we_d;
            cmd_adr_q   <= cmd_adr_d;
            cmd_sel_q   <= cmd_sel_d;
            cmd_dat_q   <= cmd_dat_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_tmo_o   = rsp_tmo_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = stb_q;
    assign wb_we_o     = cmd_we_q;
    assign wb_adr_o    = cmd_adr_q;
    assign wb_sel_o    = cmd_sel_q;
    assign wb_dat_o    = cmd_dat_q;

endmodule : wb_initiator
